// File: rtl/zone_light_arbiter.sv
// zone_light_arbiter: round-robin lamp-slot arbiter for a multi-zone lighting
// controller, with per-zone hold-off timers and manual force-on override.
module zone_light_arbiter #(
    parameter int NZONES      = 4,
    parameter int MAX_ON      = 2,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [NZONES-1:0]           infravermelho,
    input  logic [NZONES-1:0]           force_on,
    output logic [NZONES-1:0]           lamp_on,
    output logic [NZONES-1:0]           pending,
    output logic [$clog2(NZONES+1)-1:0] active_count,
    output logic                        budget_full
);
    localparam int CW = $clog2(NZONES + 1);
    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam int PW = $clog2(NZONES);
    localparam logic [TW-1:0] HOLD = TW'(HOLD_CYCLES);
    localparam logic [CW-1:0] MAXC = CW'(MAX_ON);

    typedef enum logic [1:0] {OFF, WAIT, ON_AUTO, ON_FORCED} zstate_t;

    zstate_t       r_st  [NZONES];
    logic [TW-1:0] r_tmr [NZONES];
    logic [PW-1:0] r_ptr;

    zstate_t       w_st_nx  [NZONES];
    logic [TW-1:0] w_tmr_nx [NZONES];
    logic [NZONES-1:0] w_req;
    logic [NZONES-1:0] w_grant;
    logic [NZONES-1:0] w_lamp_nx;
    logic [NZONES-1:0] w_pend_nx;
    logic [PW-1:0]     w_ptr_nx;
    logic [CW-1:0]     w_cnt_nx;

    // Forced zones never compete for a slot; force takes them directly.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NZONES; i++) begin
            w_req[i] = ~force_on[i] &
                       ((r_st[i] == WAIT) | (infravermelho[i] & (r_st[i] == OFF)));
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        w_grant  = '0;
        w_ptr_nx = r_ptr;
        found    = 1'b0;
        idx      = '0;
        if (enable && (active_count < MAXC)) begin
            for (int k = 0; k < NZONES; k++) begin
                idx = PW'((int'(r_ptr) + k) % NZONES);
                if (!found && w_req[idx]) begin
                    found        = 1'b1;
                    w_grant[idx] = 1'b1;
                    w_ptr_nx     = PW'((int'(idx) + 1) % NZONES);
                end
            end
        end
    end

    always_comb begin
        w_lamp_nx = '0;
        w_pend_nx = '0;
        w_cnt_nx  = '0;
        for (int i = 0; i < NZONES; i++) begin
            w_st_nx[i]  = r_st[i];
            w_tmr_nx[i] = r_tmr[i];
            if (force_on[i]) begin
                w_st_nx[i]  = ON_FORCED;
                w_tmr_nx[i] = '0;
            end else if (!enable) begin
                w_st_nx[i]  = OFF;
                w_tmr_nx[i] = '0;
            end else begin
                case (r_st[i])
                    OFF, WAIT: begin
                        if (w_grant[i]) begin
                            w_st_nx[i]  = ON_AUTO;
                            w_tmr_nx[i] = HOLD;
                        end else if (infravermelho[i]) begin
                            w_st_nx[i] = WAIT;
                        end
                    end
                    ON_AUTO: begin
                        if (infravermelho[i]) begin
                            w_tmr_nx[i] = HOLD;
                        end else if (r_tmr[i] < TW'(2)) begin
                            w_st_nx[i]  = OFF;
                            w_tmr_nx[i] = '0;
                        end else begin
                            w_tmr_nx[i] = r_tmr[i] - TW'(1);
                        end
                    end
                    default: begin
                        w_st_nx[i]  = ON_AUTO;
                        w_tmr_nx[i] = HOLD;
                    end
                endcase
            end
            w_lamp_nx[i] = (w_st_nx[i] == ON_AUTO) || (w_st_nx[i] == ON_FORCED);
            w_pend_nx[i] = (w_st_nx[i] == WAIT);
            w_cnt_nx     = w_cnt_nx + CW'(w_lamp_nx[i]);
        end
    end

    // Status outputs are registered from the next state so they match lamp_on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NZONES; i++) begin
                r_st[i]  <= OFF;
                r_tmr[i] <= '0;
            end
            r_ptr        <= '0;
            lamp_on      <= '0;
            pending      <= '0;
            active_count <= '0;
            budget_full  <= 1'b0;
        end else begin
            for (int i = 0; i < NZONES; i++) begin
                r_st[i]  <= w_st_nx[i];
                r_tmr[i] <= w_tmr_nx[i];
            end
            r_ptr        <= w_ptr_nx;
            lamp_on      <= w_lamp_nx;
            pending      <= w_pend_nx;
            active_count <= w_cnt_nx;
            budget_full  <= (w_cnt_nx >= MAXC) && (|w_pend_nx);
        end
    end

endmodule
